m_virtio_mmio_dev: RTL
======================

// Module: m_virtio_mmio_dev
// PURPOSE
//  Parametrised virtio-mmio (v2) device register block, successor to the single-queue disk block.
//  Holds the MMIO register file and per-queue state for NUM_QUEUES virtqueues.
//  Buffers driver notifies in a FIFO handed to the micro-controller, which also reads/writes queue state.
//  Drives one PLIC-style interrupt bit from InterruptStatus. Sits between the CPU bus mux and micro-ctrl.
// PARAMETERS
//  DEVICE_ID      2        virtio device ID returned at 0x008
//  NUM_QUEUES     1        virtqueues implemented (1..8)
//  QUEUE_NUM_MAX  8        returned at 0x034 for a valid QueueSel; QueueNum writes clamp to this
//  NOTIFY_DEPTH   4        notify FIFO entries (power of 2, >=2)
//  IRQ_BIT        1        1-based interrupt line number driven in w_oirq
//  FEATURES_LO    32'h1    DeviceFeatures word 0 (word 1 = 32'h1, VIRTIO_F_VERSION_1)
//  CONFIG0/1      0/0      config space words at 0x100/0x104 (e.g. capacity lo/hi)
// PORTS
//  CLK        in   1   clock
//  RST_X      in   1   synchronous active-low reset
//  w_mode     in   3   `MC_MODE_CPU: MMIO access; `MC_MODE_DISK: micro-ctrl queue-state access
//  w_we       in   1   write strobe (qualified by w_mode)
//  w_addr     in   12  byte address (word aligned)
//  w_idata    in   32  write data
//  w_odata    out  32  read data, registered
//  w_iirq     in   32  incoming interrupt vector
//  w_oirq     out  32  w_iirq with IRQ_BIT-1 set/cleared by this device, registered
//  w_oeirq    out  1   1-cycle pulse when this device's irq level changes
//  w_used_irq in   1   micro-ctrl pulse: used ring updated
//  w_req      out  1   notify FIFO non-empty
//  w_qsel     out  32  FIFO head queue index (zero-extended)
//  w_qnum     out  32  QueueNum of head queue
//  w_req_ack  in   1   pop FIFO head
//  w_busy     out  1   device-reset sweep in progress
// BEHAVIOUR
//  Reset (RST_X=0 at CLK edge): all outputs 0 except w_oirq=0; Status=0; all regs/queues/FIFO cleared.
//  Reads: 1-cycle latency; every read (any w_mode) updates w_odata. Unmapped offsets read 0.
//  CPU map: 0x000 magic 74726976, 0x004 ver 2, 0x008 DEVICE_ID, 0x00C ffff, 0x010 feat[sel],
//   0x014 FeatSel, 0x020/0x024 DrvFeat/Sel, 0x030 QueueSel, 0x034 NumMax, 0x038 Num, 0x044 Ready,
//   0x050 Notify(W), 0x060 IntStatus, 0x064 IntAck(W), 0x070 Status, 0x080..0x0A4 Desc/Avail/Used
//   lo/hi, 0x0FC ConfigGeneration (0), 0x100/0x104 CONFIG0/1. DeviceFeatures sel>1 reads 0.
//  QueueSel>=NUM_QUEUES: queue regs read 0, NumMax reads 0, queue writes dropped.
//  Queue state: 8 words/queue at index q*8+{0 Ready,1 Num,2 DescLo,3 DescHi,4 AvailLo,5 AvailHi,
//   6 UsedLo,7 UsedHi}; micro-ctrl index = w_addr[..:2], out-of-range reads 0/writes dropped.
//  Num write: stored min(w_idata, QUEUE_NUM_MAX).
//  Notify: w_idata<NUM_QUEUES pushes into FIFO; >=NUM_QUEUES ignored. Full: drop, set sticky
//   overflow = IntStatus bit 31 (readable, ack-clearable). Push+pop same cycle when full: both occur.
//   w_req_ack with FIFO empty ignored. w_qsel/w_qnum combinational from head.
//  IntStatus bit0 set by w_used_irq; IntAck clears written bits; set wins over same-cycle ack.
//  irq level = |IntStatus; w_oirq bit = level (1 cycle later), w_oeirq = level change, 1 cycle.
//  FSM IDLE->SWEEP on CPU write Status=0: counter clears one queue word/cycle, NUM_QUEUES*8 cycles;
//   FIFO, IntStatus, DrvFeatures, QueueSel cleared on entry. In SWEEP: w_busy=1, Status reads 0,
//   CPU and micro-ctrl writes dropped, queue reads 0. SWEEP->IDLE after last word. RST_X mid-sweep
//   aborts to IDLE with everything reset.
// CONFIGURATION
//  `VIRTIO_NOTIFY_COALESCE_EN defined: notify for a queue already pending anywhere in the FIFO is
//   dropped (no overflow flag). Undefined: every valid notify is pushed (duplicates allowed).
// STRUCTURE
//  define.vh: `MC_MODE_*, register offset localparams, VIRTIO magic/version constants.
//  Sub-module m_virtio_notify_fifo (DEPTH, WIDTH=3; push/pop/full/empty/head, pending mask).
// TESTING
//  Reset then read 0x000/0x008/0x034 -> 74726976 / DEVICE_ID / QUEUE_NUM_MAX, 1 cycle later.
//  NUM_QUEUES=2: Sel=1, write 0x080=1000, 0x038=20 -> micro-ctrl idx 10=1000, idx 9=8 (clamped).
//  5 notifies q0 with DEPTH 4, no ack -> 4 entries, IntStatus=80000000; ack 0x64=80000000 -> 0.
//  Coalesce on: notifies q1,q1,q0 -> FIFO {1,0}; off -> {1,1,0}; w_req_ack x3 -> w_req=0.
//  w_used_irq pulse -> w_oirq bit0=1 and w_oeirq pulse next cycle; ack 1 same cycle as pulse -> stays 1.
//  Status write 0 with 2 queues -> w_busy 16 cycles, queue words 0, FIFO empty; RST_X low mid-sweep.

Source files
------------

// File: rtl/m_virtio_mmio_dev_pkg.sv
// m_virtio_mmio_dev_pkg: bus modes, MMIO register offsets, virtio constants, queue-register decode
package m_virtio_mmio_dev_pkg;
    localparam logic [2:0] MC_MODE_CPU  = 3'd0;
    localparam logic [2:0] MC_MODE_DISK = 3'd1;
    localparam logic [31:0] VIRTIO_MAGIC   = 32'h7472_6976;
    localparam logic [31:0] VIRTIO_VERSION = 32'd2;
    localparam logic [11:0] REG_MAGIC         = 12'h000;
    localparam logic [11:0] REG_VERSION       = 12'h004;
    localparam logic [11:0] REG_DEVICE_ID     = 12'h008;
    localparam logic [11:0] REG_VENDOR_ID     = 12'h00C;
    localparam logic [11:0] REG_DEV_FEAT      = 12'h010;
    localparam logic [11:0] REG_DEV_FEAT_SEL  = 12'h014;
    localparam logic [11:0] REG_DRV_FEAT      = 12'h020;
    localparam logic [11:0] REG_DRV_FEAT_SEL  = 12'h024;
    localparam logic [11:0] REG_QUEUE_SEL     = 12'h030;
    localparam logic [11:0] REG_QUEUE_NUM_MAX = 12'h034;
    localparam logic [11:0] REG_QUEUE_NUM     = 12'h038;
    localparam logic [11:0] REG_QUEUE_READY   = 12'h044;
    localparam logic [11:0] REG_QUEUE_NOTIFY  = 12'h050;
    localparam logic [11:0] REG_INT_STATUS    = 12'h060;
    localparam logic [11:0] REG_INT_ACK       = 12'h064;
    localparam logic [11:0] REG_STATUS        = 12'h070;
    localparam logic [11:0] REG_DESC_LO       = 12'h080;
    localparam logic [11:0] REG_DESC_HI       = 12'h084;
    localparam logic [11:0] REG_AVAIL_LO      = 12'h090;
    localparam logic [11:0] REG_AVAIL_HI      = 12'h094;
    localparam logic [11:0] REG_USED_LO       = 12'h0A0;
    localparam logic [11:0] REG_USED_HI       = 12'h0A4;
    localparam logic [11:0] REG_CONFIG0       = 12'h100;
    localparam logic [11:0] REG_CONFIG1       = 12'h104;
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SWEEP = 1'b1;
    // {hit, word index within the queue's 8-word state block} for CPU queue registers
    function automatic logic [3:0] queue_word(input logic [11:0] a);
        return a == REG_QUEUE_READY ? 4'h8 : a == REG_QUEUE_NUM ? 4'h9 :
               a == REG_DESC_LO ? 4'hA : a == REG_DESC_HI ? 4'hB :
               a == REG_AVAIL_LO ? 4'hC : a == REG_AVAIL_HI ? 4'hD :
               a == REG_USED_LO ? 4'hE : a == REG_USED_HI ? 4'hF : 4'h0;
    endfunction
endpackage

// File: rtl/m_virtio_mmio_dev_notify_fifo.sv
// m_virtio_notify_fifo: ring FIFO of notified queue indices with a mask of queues currently pending
module m_virtio_notify_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST_X,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic                  full,
    output logic                  empty,
    output logic [WIDTH-1:0]      head,
    output logic [2**WIDTH-1:0]   pending
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp, rp, cnt;
    logic do_push, do_pop;
    assign cnt = wp - rp;
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = wp == rp;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head = mem[rp[AW-1:0]];
    // pointer/storage update; a push into a full FIFO succeeds only alongside a pop
    always_ff @(posedge CLK) begin
        if (!RST_X || clr) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp[AW-1:0]] <= din;
                wp <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
        end
    end
    // one bit per queue index held anywhere between head and tail
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if ((AW+1)'(i) < cnt) pending[mem[AW'(rp[AW-1:0] + AW'(i))]] = 1'b1;
    end
endmodule

// File: rtl/m_virtio_mmio_dev.sv
// m_virtio_mmio_dev: virtio-mmio v2 register block for NUM_QUEUES queues; `VIRTIO_NOTIFY_COALESCE_EN drops duplicate pending notifies
module m_virtio_mmio_dev
    import m_virtio_mmio_dev_pkg::*;
#(
    parameter int DEVICE_ID          = 2,
    parameter int NUM_QUEUES         = 1,
    parameter int QUEUE_NUM_MAX      = 8,
    parameter int NOTIFY_DEPTH       = 4,
    parameter int IRQ_BIT            = 1,
    parameter logic [31:0] FEATURES_LO = 32'h1,
    parameter logic [31:0] CONFIG0   = 32'h0,
    parameter logic [31:0] CONFIG1   = 32'h0
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic [2:0]  w_mode,
    input  logic        w_we,
    input  logic [11:0] w_addr,
    input  logic [31:0] w_idata,
    output logic [31:0] w_odata,
    input  logic [31:0] w_iirq,
    output logic [31:0] w_oirq,
    output logic        w_oeirq,
    input  logic        w_used_irq,
    output logic        w_req,
    output logic [31:0] w_qsel,
    output logic [31:0] w_qnum,
    input  logic        w_req_ack,
    output logic        w_busy
);
    localparam int NQW = NUM_QUEUES * 8;
`ifdef VIRTIO_NOTIFY_COALESCE_EN
    localparam logic COALESCE = 1'b1;
`else
    localparam logic COALESCE = 1'b0;
`endif
    logic state, cpu_we, disk_we, sweep_start, qsel_ok, dup, push, ovf, full, empty, wr_en, level;
    logic [5:0] cnt;
    logic [3:0] qw;
    logic [2:0] head;
    logic [7:0] pending;
    logic [9:0] cpu_idx, disk_idx, rd_idx, wr_idx;
    logic [31:0] feat_sel, drv_sel, queue_sel, status, int_status, int_next, wr_val, qs_rd, qnum, rd, irq_vec;
    logic [31:0] drv_feat [2];
    logic [31:0] qs [NQW];
    assign cpu_we = w_we && w_mode == MC_MODE_CPU && state == ST_IDLE;
    assign disk_we = w_we && w_mode == MC_MODE_DISK && state == ST_IDLE;
    assign sweep_start = cpu_we && w_addr == REG_STATUS && w_idata == 32'd0;
    assign qw = queue_word(w_addr);
    assign qsel_ok = queue_sel < 32'(NUM_QUEUES);
    assign cpu_idx = {4'd0, queue_sel[2:0], qw[2:0]};
    assign disk_idx = w_addr[11:2];
    assign rd_idx = w_mode == MC_MODE_DISK ? disk_idx : cpu_idx;
    assign wr_en = state == ST_SWEEP || (cpu_we && qw[3] && qsel_ok) || (disk_we && disk_idx < 10'(NQW));
    assign wr_idx = state == ST_SWEEP ? {4'd0, cnt} : disk_we ? disk_idx : cpu_idx;
    assign wr_val = state == ST_SWEEP ? 32'd0 : disk_we ? w_idata :
                    w_addr == REG_QUEUE_NUM ? (w_idata > 32'(QUEUE_NUM_MAX) ? 32'(QUEUE_NUM_MAX) : w_idata) :
                    w_addr == REG_QUEUE_READY ? {31'd0, w_idata[0]} : w_idata;
    assign dup = COALESCE && pending[w_idata[2:0]];
    assign push = cpu_we && w_addr == REG_QUEUE_NOTIFY && w_idata < 32'(NUM_QUEUES) && !dup;
    assign ovf = push && full && !w_req_ack;
    assign int_next = (int_status & ~(cpu_we && w_addr == REG_INT_ACK ? w_idata : 32'd0)) | {ovf, 30'd0, w_used_irq};
    assign level = |int_status;
    assign w_busy = state == ST_SWEEP;
    assign w_req = !empty;
    assign w_qsel = {29'd0, head};
    assign w_qnum = qnum;
    m_virtio_notify_fifo #(.DEPTH(NOTIFY_DEPTH), .WIDTH(3)) u_fifo (
        .CLK(CLK), .RST_X(RST_X), .clr(sweep_start), .push(push), .pop(w_req_ack),
        .din(w_idata[2:0]), .full(full), .empty(empty), .head(head), .pending(pending)
    );
    // queue-state words: single write port shared by CPU, micro-ctrl and the reset sweep
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NQW; i++)
            if (!RST_X) qs[i] <= '0;
            else if (wr_en && wr_idx == 10'(i)) qs[i] <= wr_val;
    end
    // queue-word read port and the Num word of the FIFO head queue
    always_comb begin
        qs_rd = '0;
        qnum = '0;
        for (int i = 0; i < NQW; i++) begin
            if (rd_idx == 10'(i)) qs_rd = qs[i];
            if ({4'd0, head, 3'd1} == 10'(i)) qnum = qs[i];
        end
    end
    // register map read mux; queue state is hidden while sweeping
    always_comb begin
        rd = '0;
        if (w_mode == MC_MODE_DISK) rd = state == ST_IDLE ? qs_rd : 32'd0;
        else if (qw[3]) rd = state == ST_IDLE && qsel_ok ? qs_rd : 32'd0;
        else
            case (w_addr)
                REG_MAGIC:         rd = VIRTIO_MAGIC;
                REG_VERSION:       rd = VIRTIO_VERSION;
                REG_DEVICE_ID:     rd = 32'(DEVICE_ID);
                REG_VENDOR_ID:     rd = 32'hffff;
                REG_DEV_FEAT:      rd = feat_sel == 32'd0 ? FEATURES_LO : feat_sel == 32'd1 ? 32'h1 : 32'd0;
                REG_DEV_FEAT_SEL:  rd = feat_sel;
                REG_DRV_FEAT:      rd = drv_sel < 32'd2 ? drv_feat[drv_sel[0]] : 32'd0;
                REG_DRV_FEAT_SEL:  rd = drv_sel;
                REG_QUEUE_SEL:     rd = queue_sel;
                REG_QUEUE_NUM_MAX: rd = qsel_ok ? 32'(QUEUE_NUM_MAX) : 32'd0;
                REG_INT_STATUS:    rd = int_status;
                REG_STATUS:        rd = state == ST_IDLE ? status : 32'd0;
                REG_CONFIG0:       rd = CONFIG0;
                REG_CONFIG1:       rd = CONFIG1;
                default:           rd = '0;
            endcase
    end
    // control registers, interrupt status and the IDLE/SWEEP device-reset FSM
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state <= ST_IDLE;
            cnt <= '0;
            feat_sel <= '0;
            drv_sel <= '0;
            drv_feat[0] <= '0;
            drv_feat[1] <= '0;
            queue_sel <= '0;
            status <= '0;
            int_status <= '0;
        end else begin
            int_status <= int_next;
            if (cpu_we) begin
                if (w_addr == REG_DEV_FEAT_SEL) feat_sel <= w_idata;
                if (w_addr == REG_DRV_FEAT && drv_sel < 32'd2) drv_feat[drv_sel[0]] <= w_idata;
                if (w_addr == REG_DRV_FEAT_SEL) drv_sel <= w_idata;
                if (w_addr == REG_QUEUE_SEL) queue_sel <= w_idata;
                if (w_addr == REG_STATUS) status <= w_idata;
            end
            if (sweep_start) begin
                state <= ST_SWEEP;
                cnt <= '0;
                drv_feat[0] <= '0;
                drv_feat[1] <= '0;
                queue_sel <= '0;
                int_status <= '0;
            end else if (state == ST_SWEEP) begin
                cnt <= cnt + 1'b1;
                if (cnt == 6'(NQW - 1)) state <= ST_IDLE;
            end
        end
    end
    // registered read data; write cycles leave it unchanged
    always_ff @(posedge CLK) begin
        if (!RST_X) w_odata <= '0;
        else if (!w_we) w_odata <= rd;
    end
    // pass-through interrupt vector with this device's line overlaid
    always_comb begin
        irq_vec = w_iirq;
        irq_vec[IRQ_BIT-1] = level;
    end
    // registered interrupt output and a one-cycle pulse on each level change
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            w_oirq <= '0;
            w_oeirq <= 1'b0;
        end else begin
            w_oirq <= irq_vec;
            w_oeirq <= level != w_oirq[IRQ_BIT-1];
        end
    end
endmodule
